// File: rtl/triumph_dmem_resp_pkg.sv
// rtl/triumph_dmem_resp_pkg.sv - shared types, constants and address check for the data-memory responder
package triumph_dmem_resp_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam logic [3:0] DMEM_BE_ALL = 4'b1111;

    // Misaligned, or any address bit above the array's byte range set.
    function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
        logic hi;
        hi = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if ((i >= addr_w + 2) && addr[i]) begin
                hi = 1'b1;
            end
        end
        return hi | (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/triumph_dmem_resp_if.sv
// rtl/triumph_dmem_resp_if.sv - data-side request/response channel between load/store path and data RAM
interface triumph_dmem_resp_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/triumph_dmem_ram.sv
// rtl/triumph_dmem_ram.sv - single-port word array with byte write enables and registered read, no reset
module triumph_dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    input  logic              re_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/triumph_dmem_resp.sv
// rtl/triumph_dmem_resp.sv - data-memory responder: accept FSM, wait counter, error check and response registers
module triumph_dmem_resp
    import triumph_dmem_resp_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input logic                clk_i,
    input logic                rstn_i,
    triumph_dmem_resp_if.slave bus
);

    if ((LATENCY < 0) || (LATENCY > 7)) begin : g_lat_chk
        $error("triumph_dmem_resp: LATENCY must be in 0..7");
    end
    if ((ADDR_W < 1) || (ADDR_W > 30)) begin : g_addr_chk
        $error("triumph_dmem_resp: ADDR_W must be in 1..30");
    end

    localparam logic [2:0]  CNT_LOAD  = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
    localparam dmem_state_e ACC_STATE = (LATENCY > 0) ? DMEM_WAIT : DMEM_RESP;
    localparam logic        ACC_RESP  = (LATENCY == 0);

    dmem_state_e       state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic              rd_ok_q, rd_ok_d;

    logic              gnt;
    logic              accept;
    logic              req_err;
    logic              enter_resp;
    logic              resp_we;
    logic              resp_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        enter_resp = 1'b0;
        resp_we    = we_q;
        resp_err   = err_q;

        // No grant while reset is asserted, so nothing is accepted or committed.
        gnt     = (state_q != DMEM_WAIT) && !rstn_i;
        accept  = bus.req_i && gnt;
        req_err = addr_err(bus.addr_i, ADDR_W);

        case (state_q)
            DMEM_IDLE, DMEM_RESP: begin
                if (accept) begin
                    state_d    = ACC_STATE;
                    cnt_d      = CNT_LOAD;
                    we_d       = bus.we_i;
                    err_d      = req_err;
                    addr_d     = bus.addr_i[ADDR_W+1:2];
                    enter_resp = ACC_RESP;
                    resp_we    = bus.we_i;
                    resp_err   = req_err;
                end else begin
                    state_d = DMEM_IDLE;
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d    = DMEM_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase

        rvalid_d = enter_resp;
        rerr_d   = enter_resp && resp_err;
        rd_ok_d  = enter_resp && !resp_we && !resp_err;

        // Writes use the live address on accept; reads entering RESP from WAIT use the latched one.
        ram_we   = accept && bus.we_i && !req_err;
        ram_addr = accept ? bus.addr_i[ADDR_W+1:2] : addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state_q  <= DMEM_IDLE;
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rd_ok_q  <= rd_ok_d;
        end
    end

    triumph_dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (bus.be_i),
        .wdata_i (bus.wdata_i),
        .re_i    (rd_ok_d),
        .rdata_o (ram_rdata)
    );

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = rerr_q;
    assign bus.rdata_o  = rd_ok_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_triumph_dmem_resp.sv
// tb/tb_triumph_dmem_resp.sv - scoreboard bench over four responders with latencies 1, 0, 3 and 2
module tb_triumph_dmem_resp;
    import triumph_dmem_resp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst    [4];
    logic        req    [4];
    logic        we     [4];
    logic [3:0]  be     [4];
    logic [31:0] addr   [4];
    logic [31:0] wdata  [4];
    logic        gnt_w  [4];
    logic        rvalid_w [4];
    logic [31:0] rdata_w  [4];
    logic        err_w    [4];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 2;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gd
        triumph_dmem_resp_if bus ();
        assign bus.req_i   = req[g];
        assign bus.we_i    = we[g];
        assign bus.be_i    = be[g];
        assign bus.addr_i  = addr[g];
        assign bus.wdata_i = wdata[g];
        assign gnt_w[g]    = bus.gnt_o;
        assign rvalid_w[g] = bus.rvalid_o;
        assign rdata_w[g]  = bus.rdata_o;
        assign err_w[g]    = bus.err_o;

        triumph_dmem_resp #(
            .ADDR_W  (10),
            .LATENCY ((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 2)
        ) dut (
            .clk_i  (clk),
            .rstn_i (rst[g]),
            .bus    (bus)
        );
    end

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rvalid_w[d]) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid: dut %0d gave a response with none pending (cycle %0d)", d, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_dut", 32'(d), 32'(e.d));
                    chk("resp_cycle", 32'(cyc), 32'(e.due));
                    chk("resp_rdata", rdata_w[d], e.rdata);
                    chk("resp_err", {31'd0, err_w[d]}, {31'd0, e.err});
                end
            end else begin
                chk("idle_rdata", rdata_w[d], 32'h0);
                chk("idle_err", {31'd0, err_w[d]}, 32'h0);
            end
        end
    end

    task automatic issue(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee, input bit push,
                         output int waited, output logic rv_acc);
        bit acc;
        exp_t x;
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        waited = 0; acc = 0; rv_acc = 1'b0;
        while (!acc && waited < 50) begin
            @(negedge clk);
            if (gnt_w[d]) begin
                acc = 1;
                rv_acc = rvalid_w[d];
            end else begin
                waited++;
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: dut %0d addr 0x%08h never granted", d, a);
            req[d] = 1'b0;
        end else begin
            if (push) begin
                x.d = d; x.rdata = er; x.err = ee; x.due = cyc + 1 + lat_of(d);
                sb.push_back(x);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop(input int d);
        req[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Accept a transaction on the LATENCY=3 responder, then pulse reset in its second wait cycle
    // while a stray write is presented.
    task automatic reset_mid(input logic w, input logic [31:0] a, input logic [31:0] wd);
        int wt;
        logic rv;
        issue(2, w, DMEM_BE_ALL, a, wd, 32'h0, 1'b0, 0, wt, rv);
        drop(2);
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        req[2] = 1'b1; we[2] = 1'b1; be[2] = DMEM_BE_ALL; addr[2] = 32'h8; wdata[2] = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_mid_gnt_low", {31'd0, gnt_w[2]}, 32'h0);
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        req[2] = 1'b0;
        @(negedge clk);
        chk("rst_mid_gnt_after", {31'd0, gnt_w[2]}, 32'h1);
        chk("rst_mid_rvalid_after", {31'd0, rvalid_w[2]}, 32'h0);
        idle(8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        logic rv;
        for (int d = 0; d < 4; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) chk("reset_gnt_low", {31'd0, gnt_w[d]}, 32'h0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("post_reset_gnt", {31'd0, gnt_w[d]}, 32'h1);
            chk("post_reset_rvalid", {31'd0, rvalid_w[d]}, 32'h0);
        end
        @(posedge clk);
        #1;

        // LATENCY=1: full write/read, byte mask, no-op write, error cases, top word
        issue(0, 1, DMEM_BE_ALL, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1, wt, rv);
        chk("l1_first_gnt_wait", 32'(wt), 32'h0);
        drop(0);
        idle(3);
        issue(0, 0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1, wt, rv);
        issue(0, 1, DMEM_BE_ALL, 32'h20, 32'h1122_3344, 32'h0, 0, 1, wt, rv);
        issue(0, 1, 4'b0101, 32'h20, 32'hAABB_CCDD, 32'h0, 0, 1, wt, rv);
        issue(0, 0, 4'h0, 32'h20, 32'h0, 32'h11BB_33DD, 0, 1, wt, rv);
        issue(0, 1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 32'h0, 0, 1, wt, rv);
        issue(0, 0, 4'h0, 32'h20, 32'h0, 32'h11BB_33DD, 0, 1, wt, rv);
        issue(0, 1, DMEM_BE_ALL, 32'h0, 32'h5A5A_5A5A, 32'h0, 0, 1, wt, rv);
        issue(0, 0, 4'h0, 32'h2, 32'h0, 32'h0, 1, 1, wt, rv);
        issue(0, 1, DMEM_BE_ALL, 32'h1000, 32'hFFFF_FFFF, 32'h0, 1, 1, wt, rv);
        issue(0, 1, DMEM_BE_ALL, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0, 1, 1, wt, rv);
        issue(0, 0, 4'h0, 32'h0, 32'h0, 32'h5A5A_5A5A, 0, 1, wt, rv);
        issue(0, 0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1, wt, rv);
        issue(0, 1, DMEM_BE_ALL, 32'hFFC, 32'hCAFE_F00D, 32'h0, 0, 1, wt, rv);
        issue(0, 0, 4'h0, 32'hFFC, 32'h0, 32'hCAFE_F00D, 0, 1, wt, rv);
        issue(0, 0, 4'h0, 32'h1FFC, 32'h0, 32'h0, 1, 1, wt, rv);
        drop(0);
        idle(4);

        // LATENCY=0: back-to-back with req held, grant every cycle
        issue(1, 1, DMEM_BE_ALL, 32'h0, 32'h0000_0100, 32'h0, 0, 1, wt, rv);
        chk("l0_gnt_w0", 32'(wt), 32'h0);
        issue(1, 1, DMEM_BE_ALL, 32'h4, 32'h0000_0200, 32'h0, 0, 1, wt, rv);
        chk("l0_gnt_w1", 32'(wt), 32'h0);
        issue(1, 1, DMEM_BE_ALL, 32'h8, 32'h0000_0300, 32'h0, 0, 1, wt, rv);
        chk("l0_gnt_w2", 32'(wt), 32'h0);
        issue(1, 0, 4'h0, 32'h0, 32'h0, 32'h0000_0100, 0, 1, wt, rv);
        chk("l0_gnt_r0", 32'(wt), 32'h0);
        issue(1, 0, 4'h0, 32'h4, 32'h0, 32'h0000_0200, 0, 1, wt, rv);
        chk("l0_gnt_r1", 32'(wt), 32'h0);
        chk("l0_r1_in_resp", {31'd0, rv}, 32'h1);
        issue(1, 0, 4'h0, 32'h8, 32'h0, 32'h0000_0300, 0, 1, wt, rv);
        chk("l0_gnt_r2", 32'(wt), 32'h0);
        drop(1);
        idle(4);

        // LATENCY=3: reset mid-operation drops responses; earlier write already committed
        reset_mid(1'b1, 32'h8, 32'h0BAD_CAFE);
        reset_mid(1'b0, 32'h8, 32'h0);
        issue(2, 0, 4'h0, 32'h8, 32'h0, 32'h0BAD_CAFE, 0, 1, wt, rv);
        drop(2);
        idle(8);

        // LATENCY=2: request raised in WAIT stalls until RESP
        issue(3, 1, DMEM_BE_ALL, 32'h4, 32'h0000_0077, 32'h0, 0, 1, wt, rv);
        drop(3);
        idle(5);
        issue(3, 0, 4'h0, 32'h4, 32'h0, 32'h0000_0077, 0, 1, wt, rv);
        issue(3, 0, 4'h0, 32'h4, 32'h0, 32'h0000_0077, 0, 1, wt, rv);
        chk("stall_wait_cycles", 32'(wt), 32'h2);
        chk("stall_accept_in_resp", {31'd0, rv}, 32'h1);
        drop(3);
        idle(10);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
